// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, NOP word, XLEN, reset PC.
// Also provides the PC increment helper used by the PC register and the o_pc_next output.
// No logic of its own; imported by rv_fetch and rv_fetch_pc.
package rv_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] RV_NOP        = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] RV_PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  // Sequential PC: +4, wrapping modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + RV_PC_STEP;
  endfunction

endpackage

// File: rtl/rv_fetch_pc.sv
// Program counter register with next-PC mux: redirect has priority over +4, else hold.
// Latency: new PC visible the cycle after i_load / i_advance.
// No backpressure of its own; the fetch FSM decides when to load or advance.
module rv_fetch_pc
  import rv_pkg::*;
#(
  parameter logic [rv_pkg::XLEN-1:0] RESET_ADDR = rv_pkg::RV_RESET_ADDR
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_load,
  input  logic [rv_pkg::XLEN-1:0] i_target,
  input  logic                    i_advance,
  output logic [rv_pkg::XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;

  // Next-PC select: redirect target, sequential step, or hold.
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_load) begin
      w_pc_nxt = i_target;
    end else if (i_advance) begin
      w_pc_nxt = pc_inc(r_pc);
    end
  end

  // PC register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= RESET_ADDR;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch: owns the PC, issues single-beat bus reads, registers {instr, pc} for decode.
// Latency: issue cycle -> o_valid is ack cycle + 1; zero-wait bus sustains 1 instr per 2 clocks.
// Backpressure: i_stall blocks issue and consumption; optional RV_FETCH_ALIGN_CHK_EN adds o_misaligned.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [rv_pkg::XLEN-1:0] RESET_ADDR = rv_pkg::RV_RESET_ADDR,
  parameter int                      XLEN       = rv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_stall,
  input  logic            i_pc_select,
  input  logic [XLEN-1:0] i_pc_target,
  output logic            o_ibus_req,
  output logic [XLEN-1:0] o_ibus_addr,
  input  logic            i_ibus_ack,
  input  logic [31:0]     i_ibus_data,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_valid,
  output logic            o_busy
`ifdef RV_FETCH_ALIGN_CHK_EN
  ,
  output logic            o_misaligned
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_pc_out;
  logic [31:0]     r_instr;
  logic            r_valid;

  logic            w_consume;
  logic            w_busy;
  logic            w_issue;
  logic            w_capture;
  logic            w_issue_blk;

  assign w_consume = r_valid && !i_stall;
  assign w_busy    = (r_state == REQ) || (r_state == KILL);
  // A request raised from IDLE/HOLD is a fresh issue; its address is latched for the transfer.
  assign w_issue   = o_ibus_req && !w_busy;

`ifdef RV_FETCH_ALIGN_CHK_EN
  logic r_misaligned;

  assign w_target    = i_pc_target;
  // A misaligned target parks fetch in IDLE until an aligned redirect arrives.
  assign w_issue_blk = r_misaligned;

  // Misalignment flag: every redirect re-evaluates it, so an aligned one clears it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_misaligned <= 1'b0;
    end else if (i_pc_select) begin
      r_misaligned <= (i_pc_target[1:0] != 2'b00);
    end
  end

  assign o_misaligned = r_misaligned;
`else
  // Without the check, the low two target bits are simply ignored.
  assign w_target    = i_pc_target & ~XLEN'(3);
  assign w_issue_blk = 1'b0;
`endif

  rv_fetch_pc #(
    .RESET_ADDR (RESET_ADDR)
  ) u_pc (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (i_pc_select),
    .i_target  (w_target),
    .i_advance (w_capture),
    .o_pc      (w_pc)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, bus request and capture strobe. Redirect wins over ack and consume everywhere.
  // The ack is only honoured once a request is outstanding (REQ/KILL), i.e. from the cycle
  // after issue onward. A misaligned redirect while a read is outstanding still drains it via
  // KILL so the bus never sees the request withdrawn before its ack.
  always_comb begin
    w_state_nxt = r_state;
    o_ibus_req  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_pc_select && !i_stall && !w_issue_blk) begin
          o_ibus_req  = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        o_ibus_req = 1'b1;
        if (i_pc_select) begin
          w_state_nxt = i_ibus_ack ? IDLE : KILL;
        end else if (i_ibus_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (i_pc_select) begin
          w_state_nxt = IDLE;
        end else if (w_consume) begin
          // Back-to-back issue at the already advanced PC.
          o_ibus_req  = 1'b1;
          w_state_nxt = REQ;
        end
      end
      KILL: begin
        o_ibus_req = 1'b1;
        if (i_ibus_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bus address latch: held at the issued PC until the ack, even if the PC is redirected.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr <= RESET_ADDR;
    end else if (w_issue) begin
      r_addr <= w_pc;
    end
  end

  // Decode-facing output registers: fill on good ack, drop valid on consume or redirect.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_instr  <= RV_NOP;
      r_pc_out <= RESET_ADDR;
      r_valid  <= 1'b0;
    end else begin
      if (i_pc_select) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_instr  <= i_ibus_data;
        r_pc_out <= r_addr;
        r_valid  <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_ibus_addr = w_busy ? r_addr : w_pc;
  assign o_instr     = r_instr;
  assign o_pc        = r_pc_out;
  assign o_pc_next   = pc_inc(r_pc_out);
  assign o_valid     = r_valid;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_rv_fetch.sv
// Directed bench for rv_fetch: instance A at reset address 0, instance B at 32'hFFFF_FFFC.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Covers reset, zero-wait and wait-state fetch, stall, redirect in REQ/KILL/HOLD, PC wrap.
module tb_rv_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Instance A signals
  logic        a_rst_n, a_stall, a_psel, a_ack, a_req, a_valid, a_busy;
  logic [31:0] a_tgt, a_data, a_addr, a_instr, a_pc, a_pc_next;
  // Instance B signals
  logic        b_rst_n, b_stall, b_psel, b_ack, b_req, b_valid, b_busy;
  logic [31:0] b_tgt, b_data, b_addr, b_instr, b_pc, b_pc_next;
`ifdef RV_FETCH_ALIGN_CHK_EN
  logic        a_mis, b_mis;
`endif

  rv_fetch #(.RESET_ADDR(32'h0000_0000)) u_dut_a (
    .i_clk       (clk),
    .i_reset_n   (a_rst_n),
    .i_stall     (a_stall),
    .i_pc_select (a_psel),
    .i_pc_target (a_tgt),
    .o_ibus_req  (a_req),
    .o_ibus_addr (a_addr),
    .i_ibus_ack  (a_ack),
    .i_ibus_data (a_data),
    .o_instr     (a_instr),
    .o_pc        (a_pc),
    .o_pc_next   (a_pc_next),
    .o_valid     (a_valid),
    .o_busy      (a_busy)
`ifdef RV_FETCH_ALIGN_CHK_EN
    ,
    .o_misaligned(a_mis)
`endif
  );

  rv_fetch #(.RESET_ADDR(32'hFFFF_FFFC)) u_dut_b (
    .i_clk       (clk),
    .i_reset_n   (b_rst_n),
    .i_stall     (b_stall),
    .i_pc_select (b_psel),
    .i_pc_target (b_tgt),
    .o_ibus_req  (b_req),
    .o_ibus_addr (b_addr),
    .i_ibus_ack  (b_ack),
    .i_ibus_data (b_data),
    .o_instr     (b_instr),
    .o_pc        (b_pc),
    .o_pc_next   (b_pc_next),
    .o_valid     (b_valid),
    .o_busy      (b_busy)
`ifdef RV_FETCH_ALIGN_CHK_EN
    ,
    .o_misaligned(b_mis)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    a_rst_n = 1'b0; a_stall = 1'b1; a_psel = 1'b0; a_tgt = '0; a_ack = 1'b0; a_data = '0;
    b_rst_n = 1'b0; b_stall = 1'b1; b_psel = 1'b0; b_tgt = '0; b_ack = 1'b0; b_data = '0;
    #12;

    // Reset state
    chk("rst_valid",   32'(a_valid), 32'd0);
    chk("rst_instr",   a_instr,      32'h0000_0013);
    chk("rst_pc",      a_pc,         32'h0);
    chk("rst_pc_next", a_pc_next,    32'h4);
    chk("rst_busy",    32'(a_busy),  32'd0);
    chk("rst_req",     32'(a_req),   32'd0);
    chk("rstB_pc",     b_pc,         32'hFFFF_FFFC);
    chk("rstB_pc_nxt", b_pc_next,    32'h0);

    // First fetch, zero-wait bus
    tick(); a_rst_n = 1'b1; a_stall = 1'b0; settle();
    chk("c0_req",  32'(a_req),  32'd1);
    chk("c0_addr", a_addr,      32'h0);
    chk("c0_busy", 32'(a_busy), 32'd0);
    tick(); a_ack = 1'b1; a_data = 32'h0050_0093; settle();
    chk("c1_req",   32'(a_req),   32'd1);
    chk("c1_addr",  a_addr,       32'h0);
    chk("c1_busy",  32'(a_busy),  32'd1);
    chk("c1_valid", 32'(a_valid), 32'd0);
    tick(); a_ack = 1'b0; settle();
    chk("c2_valid",   32'(a_valid), 32'd1);
    chk("c2_instr",   a_instr,      32'h0050_0093);
    chk("c2_pc",      a_pc,         32'h0);
    chk("c2_pc_next", a_pc_next,    32'h4);
    chk("c2_req",     32'(a_req),   32'd1);
    chk("c2_addr",    a_addr,       32'h4);

    // Ack held low for 3 clocks
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("wait_req",   32'(a_req),   32'd1);
      chk("wait_addr",  a_addr,       32'h4);
      chk("wait_busy",  32'(a_busy),  32'd1);
      chk("wait_valid", 32'(a_valid), 32'd0);
    end
    a_ack = 1'b1; a_data = 32'h00A0_0113; settle();

    // Stall while holding a valid instruction
    tick(); a_ack = 1'b0; a_stall = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(a_valid), 32'd1);
      chk("stall_instr", a_instr,      32'h00A0_0113);
      chk("stall_pc",    a_pc,         32'h4);
      chk("stall_req",   32'(a_req),   32'd0);
      tick(); settle();
    end
    a_stall = 1'b0; settle();
    chk("unstall_req",  32'(a_req), 32'd1);
    chk("unstall_addr", a_addr,     32'h8);

    // Redirect while REQ is unacked -> KILL, old address held, returned word dropped
    tick(); a_psel = 1'b1; a_tgt = 32'h100; settle();
    chk("redir_valid", 32'(a_valid), 32'd0);
    chk("redir_addr",  a_addr,       32'h8);
    tick(); a_psel = 1'b0; settle();
    chk("kill_busy", 32'(a_busy), 32'd1);
    chk("kill_req",  32'(a_req),  32'd1);
    chk("kill_addr", a_addr,      32'h8);
    a_ack = 1'b1; a_data = 32'hBAD0_BAD0; settle();
    tick(); a_ack = 1'b0; settle();
    chk("killed_valid", 32'(a_valid), 32'd0);
    chk("killed_instr", a_instr,      32'h00A0_0113);
    chk("killed_busy",  32'(a_busy),  32'd0);
    chk("killed_req",   32'(a_req),   32'd1);
    chk("killed_addr",  a_addr,       32'h100);

    // Redirect coincident with ack -> data dropped
    tick(); a_ack = 1'b1; a_data = 32'h1111_1111; a_psel = 1'b1; a_tgt = 32'h200; settle();
    chk("coin_addr", a_addr, 32'h100);
    tick(); a_ack = 1'b0; a_psel = 1'b0; settle();
    chk("coin_valid", 32'(a_valid), 32'd0);
    chk("coin_instr", a_instr,      32'h00A0_0113);
    chk("coin_req",   32'(a_req),   32'd1);
    chk("coin_addr2", a_addr,       32'h200);
    chk("coin_busy",  32'(a_busy),  32'd0);

    // Fetch at 0x200, then redirect out of HOLD
    tick(); a_ack = 1'b1; a_data = 32'h0020_8193; settle();
    tick(); a_ack = 1'b0; a_stall = 1'b1; a_psel = 1'b1; a_tgt = 32'h300; settle();
    chk("h_valid",   32'(a_valid), 32'd1);
    chk("h_pc",      a_pc,         32'h200);
    chk("h_pc_next", a_pc_next,    32'h204);
    chk("h_instr",   a_instr,      32'h0020_8193);
    chk("h_req",     32'(a_req),   32'd0);
    tick(); a_psel = 1'b0; a_stall = 1'b0; settle();
    chk("hr_valid", 32'(a_valid), 32'd0);
    chk("hr_req",   32'(a_req),   32'd1);
    chk("hr_addr",  a_addr,       32'h300);
    a_stall = 1'b1;

    // Instance B: PC wrap from 32'hFFFF_FFFC
    tick(); b_rst_n = 1'b1; b_stall = 1'b0; settle();
    chk("B_req0",  32'(b_req), 32'd1);
    chk("B_addr0", b_addr,     32'hFFFF_FFFC);
    tick(); b_ack = 1'b1; b_data = 32'h0010_0073; settle();
    tick(); b_ack = 1'b0; settle();
    chk("B_valid1",   32'(b_valid), 32'd1);
    chk("B_pc1",      b_pc,         32'hFFFF_FFFC);
    chk("B_pc_next1", b_pc_next,    32'h0);
    chk("B_req1",     32'(b_req),   32'd1);
    chk("B_addr1",    b_addr,       32'h0);
    tick(); b_ack = 1'b1; b_data = 32'h0030_0193; settle();
    tick(); b_ack = 1'b0; b_stall = 1'b1; settle();
    chk("B_valid2",   32'(b_valid), 32'd1);
    chk("B_instr2",   b_instr,      32'h0030_0193);
    chk("B_pc2",      b_pc,         32'h0);
    chk("B_pc_next2", b_pc_next,    32'h4);

    // Misaligned redirect target
    b_psel = 1'b1; b_tgt = 32'h102; settle();
    tick(); b_psel = 1'b0; b_stall = 1'b0; settle();
`ifdef RV_FETCH_ALIGN_CHK_EN
    chk("B_mis_set",   32'(b_mis),   32'd1);
    chk("B_mis_valid", 32'(b_valid), 32'd0);
    chk("B_mis_req",   32'(b_req),   32'd0);
    tick(); settle();
    chk("B_mis_req2",  32'(b_req),   32'd0);
    chk("B_mis_busy",  32'(b_busy),  32'd0);
    b_psel = 1'b1; b_tgt = 32'h200; settle();
    tick(); b_psel = 1'b0; settle();
    chk("B_mis_clr",  32'(b_mis), 32'd0);
    chk("B_al_req",   32'(b_req), 32'd1);
    chk("B_al_addr",  b_addr,     32'h200);
`else
    chk("B_al_valid", 32'(b_valid), 32'd0);
    chk("B_al_req",   32'(b_req),   32'd1);
    chk("B_al_addr",  b_addr,       32'h100);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
